adc_mem_ctrl: RTL and testbench
===============================

// Module: adc_mem_ctrl
// PURPOSE
//  Single-shot ADC capture engine. On a CSR start pulse it streams NUM_SAMPLES consecutive packed
//  AD9238 samples (one per clock) into the ADC write port of soc_ram, starting at ADDR_START.
//  It then flags completion to the CSR block. Sits between the ADC input pipeline and the soc_ram
//  second (ADC) port; the CPU reads results over soc_if.
// PARAMETERS
//  ADDR_W       13       width of RAM word address (soc_ram NUM_WORDS=8192)
//  ADDR_START   13'h400  first RAM word address written
//  NUM_SAMPLES  4096     samples per acquisition; ADDR_START+NUM_SAMPLES <= 2**ADDR_W (elab check)
// PORTS
//  sys_clk        in   1       ADC/system clock (65 MHz), single clock domain
//  sys_rst        in   1       synchronous, active-high reset
//  adc_sample_in  in   32      adc_sample_t {unused1[31:28], ch1[27:16], unused0[15:12], ch0[11:0]}
//  csr_start_i    in   1       start request, sampled on rising edge of sys_clk (1-cycle pulse typical)
//  csr_done_o     out  1       acquisition complete
//  adc_we_o       out  1       RAM write enable (soc_ram writes on sys_clk edge when high)
//  adc_data_o     out  32      adc_sample_t word to RAM
//  adc_addr_o     out  ADDR_W  RAM word address
// BEHAVIOUR
//  - State reg acq_state_r, enum {IDLE, CAPTURE, DONE}; sample counter cnt_r, width clog2(NUM_SAMPLES)+1.
//  - Reset (sync, any state incl. mid-capture): state=IDLE, adc_we_o=0, csr_done_o=0,
//    adc_addr_o=ADDR_START, cnt_r=0. A partial capture is abandoned; RAM contents are left as-is.
//  - IDLE: we=0, done=0. csr_start_i=1 at edge -> CAPTURE; same edge sets we=1, addr=ADDR_START, cnt=0.
//  - CAPTURE: each edge with we=1 writes one word. Next addr=addr+1, cnt=cnt+1.
//    The edge on which cnt==NUM_SAMPLES-1 (addr=ADDR_START+NUM_SAMPLES-1) is the last write.
//    That same edge clears we, sets done=1, and goes to DONE; addr holds the last address.
//  - Exactly NUM_SAMPLES write cycles, contiguous, no gaps. First we=1 is the cycle after start is sampled.
//  - adc_data_o = adc_sample_in combinationally (zero latency), so the word written at an edge is the
//    sample present at that edge; unused nibbles pass through unchanged (upstream drives 0).
//  - adc_we_o, adc_addr_o, csr_done_o are registered outputs (glitch-free).
//  - csr_start_i while in CAPTURE: ignored, and the acquisition is not restarted.
//  - DONE: we=0, done held 1 until next csr_start_i. Start in DONE -> CAPTURE with done cleared,
//    addr=ADDR_START, and the same timing as from IDLE.
//  - Address never wraps (guaranteed by parameter check); no back-pressure; the RAM always accepts writes.
// TESTING
//  1. Reset 10 cycles, release, 1-cycle start, ch0 from 0xAAA and ch1 from 0x555, both +1 per write cycle
//     -> mem[0x400+i] == {4'h0, (0x555+i)[11:0], 4'h0, (0xAAA+i)[11:0]} for i=0..4095; 0 mismatches.
//  2. Write-window timing: start sampled at edge T -> we=1 on cycles T+1..T+4096, addr 0x400..0x13FF;
//     done=1 from T+4097 onward, we=0. mem[0x3FF] and mem[0x1400] are untouched.
//  3. Start held high 5 cycles / pulsed again mid-capture -> still exactly 4096 writes, done asserts once.
//  4. Re-arm: after done, new start with ch0=0x123 -> done drops, 4096 new writes overwrite 0x400..,
//     and done rises again.
//  5. sys_rst=1 during CAPTURE at sample 100 -> next cycle we=0, done=0, state IDLE, addr=0x400.
//     A subsequent start completes a normal capture.
//  6. No start after reset for 1000 cycles -> we stays 0, done stays 0, memory unchanged.

Source files
------------

// File: rtl/adc_mem_ctrl.sv
// ---------------------------------------------------------------------------
// adc_mem_ctrl
//   Single-shot ADC capture engine. A start request streams NUM_SAMPLES
//   consecutive packed AD9238 samples, one per clock, into the ADC write port
//   of soc_ram. The first word goes to ADDR_START. When the block finishes it
//   raises a done flag toward the CSR block. The flag stays high until the
//   next start request.
//
// Ports
//   sys_clk        in   1       ADC/system clock, single clock domain
//   sys_rst        in   1       synchronous, active-high reset
//   adc_sample_in  in   32      {unused1[31:28], ch1[27:16], unused0[15:12], ch0[11:0]}
//   csr_start_i    in   1       start request, sampled on the rising clock edge
//   csr_done_o     out  1       acquisition complete (registered)
//   adc_we_o       out  1       RAM write enable (registered)
//   adc_data_o     out  32      sample word to RAM (combinational pass-through)
//   adc_addr_o     out  ADDR_W  RAM word address (registered)
// ---------------------------------------------------------------------------
module adc_mem_ctrl #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned ADDR_START  = 'h400,
  parameter int unsigned NUM_SAMPLES = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       adc_sample_in,
  input  logic              csr_start_i,
  output logic              csr_done_o,
  output logic              adc_we_o,
  output logic [31:0]       adc_data_o,
  output logic [ADDR_W-1:0] adc_addr_o
);

  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES) + 1;

  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ADDR_START);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_SAMPLES - 1);

  // The capture window must fit in the RAM, because the address never wraps.
  if ((longint'(ADDR_START) + longint'(NUM_SAMPLES) > (longint'(1) << ADDR_W)) ||
      (NUM_SAMPLES < 1)) begin : g_range_check
    $error("adc_mem_ctrl: capture window does not fit in the RAM address space");
  end

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } acq_state_t;

  acq_state_t        acq_state_r, acq_state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic              we_r, we_nxt;
  logic              done_r, done_nxt;

  // The sample goes straight to the RAM data port, so the RAM stores the
  // sample that is present on the same edge that writes it.
  assign adc_data_o = adc_sample_in;
  assign adc_we_o   = we_r;
  assign adc_addr_o = addr_r;
  assign csr_done_o = done_r;

  // ---- state / registered-output stage ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acq_state_r <= IDLE;
      cnt_r       <= '0;
      addr_r      <= ADDR_FIRST;
      we_r        <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      acq_state_r <= acq_state_nxt;
      cnt_r       <= cnt_nxt;
      addr_r      <= addr_nxt;
      we_r        <= we_nxt;
      done_r      <= done_nxt;
    end
  end

  // While in CAPTURE, cnt_r and addr_r describe the write that happens on the
  // coming edge. The write is the last one when cnt_r reaches CNT_LAST.
  always_comb begin
    acq_state_nxt = acq_state_r;
    cnt_nxt       = cnt_r;
    addr_nxt      = addr_r;
    we_nxt        = we_r;
    done_nxt      = done_r;

    unique case (acq_state_r)
      IDLE, DONE: begin
        we_nxt = 1'b0;
        if (csr_start_i) begin
          acq_state_nxt = CAPTURE;
          we_nxt        = 1'b1;
          done_nxt      = 1'b0;
          addr_nxt      = ADDR_FIRST;
          cnt_nxt       = '0;
        end
      end
      CAPTURE: begin
        // A start request during capture is ignored.
        if (cnt_r == CNT_LAST) begin
          acq_state_nxt = DONE;
          we_nxt        = 1'b0;
          done_nxt      = 1'b1;
        end else begin
          we_nxt   = 1'b1;
          addr_nxt = addr_r + 1'b1;
          cnt_nxt  = cnt_r + 1'b1;
        end
      end
      default: begin
        acq_state_nxt = IDLE;
        we_nxt        = 1'b0;
        done_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_mem_ctrl
//   Directed bench for adc_mem_ctrl. It uses a behavioural soc_ram ADC port
//   model that is pre-filled with address-tagged sentinel words. The ch0 and
//   ch1 ramps are driven relative to the start edge.
// ---------------------------------------------------------------------------
module tb_adc_mem_ctrl;

  localparam int ADDR_W = 13;
  localparam int ADDR0  = 'h400;
  localparam int NS     = 4096;
  localparam int NWORDS = 8192;

  logic              sys_clk;
  logic              sys_rst;
  logic [31:0]       adc_sample_in;
  logic              csr_start_i;
  logic              csr_done_o;
  logic              adc_we_o;
  logic [31:0]       adc_data_o;
  logic [ADDR_W-1:0] adc_addr_o;

  adc_mem_ctrl #(
    .ADDR_W     (ADDR_W),
    .ADDR_START (ADDR0),
    .NUM_SAMPLES(NS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .adc_sample_in(adc_sample_in),
    .csr_start_i  (csr_start_i),
    .csr_done_o   (csr_done_o),
    .adc_we_o     (adc_we_o),
    .adc_data_o   (adc_data_o),
    .adc_addr_o   (adc_addr_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sentinel(input int a);
    logic [12:0] a13;
    a13 = 13'(a);
    return {16'hDEAD, 3'b000, a13};
  endfunction

  // RAM model for the ADC port, with counters for writes and rising edges of done.
  logic [31:0] mem [0:NWORDS-1];
  bit          mem_init = 1'b0;
  int          wr_cnt   = 0;
  int          rises    = 0;
  logic        done_q   = 1'b0;

  always @(posedge sys_clk) begin
    if (!mem_init) begin
      for (int a = 0; a < NWORDS; a++) mem[a] <= sentinel(a);
      mem_init <= 1'b1;
    end else if (adc_we_o) begin
      mem[adc_addr_o] <= adc_data_o;
      wr_cnt          <= wr_cnt + 1;
    end
    done_q <= csr_done_o;
    if (csr_done_o && !done_q) rises <= rises + 1;
  end

  // Issue a one-edge start request (or hold it for 'hold' edges). Then drive
  // sample i during the cycle whose write lands at ADDR0+i. 'mid' re-pulses
  // start during the capture. 'rst_at' asserts reset while sample rst_at is
  // being written and then abandons the capture.
  task automatic run_capture(input logic [11:0] c0, input logic [11:0] c1,
                             input int hold, input int mid, input int rst_at);
    int base_wr, base_rise, bad_win, bad_mem, bad_hold;
    logic [11:0] e0, e1;
    @(negedge sys_clk);
    csr_start_i = 1'b1;
    base_wr     = wr_cnt;
    base_rise   = rises;
    @(posedge sys_clk); #1;
    chk("first_we", adc_we_o, 1);
    chk("first_addr", adc_addr_o, ADDR0);
    chk("first_done", csr_done_o, 0);
    bad_win = 0;
    for (int i = 0; i < NS; i++) begin
      if (adc_we_o !== 1'b1 || adc_addr_o !== 13'(ADDR0 + i) || csr_done_o !== 1'b0)
        bad_win++;
      adc_sample_in = {4'h0, c1 + 12'(i), 4'h0, c0 + 12'(i)};
      csr_start_i   = (i < hold - 1) || (i == mid);
      if (i == rst_at) sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      if (i == rst_at) begin
        sys_rst     = 1'b0;
        csr_start_i = 1'b0;
        chk("rst_win", bad_win, 0);
        chk("rst_we", adc_we_o, 0);
        chk("rst_done", csr_done_o, 0);
        chk("rst_addr", adc_addr_o, ADDR0);
        chk("rst_writes", wr_cnt - base_wr, rst_at + 1);
        return;
      end
    end
    csr_start_i = 1'b0;
    chk("win", bad_win, 0);
    chk("end_we", adc_we_o, 0);
    chk("end_done", csr_done_o, 1);
    chk("end_addr", adc_addr_o, ADDR0 + NS - 1);
    chk("writes", wr_cnt - base_wr, NS);
    bad_mem = 0;
    for (int i = 0; i < NS; i++) begin
      e0 = c0 + 12'(i);
      e1 = c1 + 12'(i);
      if (mem[ADDR0 + i] !== {4'h0, e1, 4'h0, e0}) bad_mem++;
    end
    chk("mem_data", bad_mem, 0);
    chk("below_untouched", mem[ADDR0 - 1], sentinel(ADDR0 - 1));
    chk("above_untouched", mem[ADDR0 + NS], sentinel(ADDR0 + NS));
    bad_hold = 0;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (adc_we_o !== 1'b0 || csr_done_o !== 1'b1) bad_hold++;
    end
    chk("done_hold", bad_hold, 0);
    chk("done_rises", rises - base_rise, 1);
  endtask

  initial begin
    int bad_idle;
    sys_rst       = 1'b1;
    csr_start_i   = 1'b0;
    adc_sample_in = '0;

    // Reset for 10 cycles.
    repeat (10) @(posedge sys_clk);
    #1;
    chk("reset_we", adc_we_o, 0);
    chk("reset_done", csr_done_o, 0);
    chk("reset_addr", adc_addr_o, ADDR0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Without a start request, nothing happens.
    bad_idle = 0;
    repeat (1000) begin
      @(posedge sys_clk); #1;
      if (adc_we_o !== 1'b0 || csr_done_o !== 1'b0) bad_idle++;
    end
    chk("idle_quiet", bad_idle, 0);
    chk("idle_writes", wr_cnt, 0);

    // Basic capture and write-window timing.
    run_capture(12'hAAA, 12'h555, 1, -1, -1);
    chk("t1_first_word", mem['h400], 32'h0555_0AAA);
    chk("t1_last_word", mem['h13FF], 32'h0554_0AA9);

    // Start held for 5 cycles plus a mid-capture pulse.
    run_capture(12'h000, 12'h800, 5, 2000, -1);
    chk("t3_first_word", mem['h400], 32'h0800_0000);
    chk("t3_last_word", mem['h13FF], 32'h07FF_0FFF);

    // Re-arm from DONE.
    run_capture(12'h123, 12'h321, 1, -1, -1);
    chk("t4_first_word", mem['h400], 32'h0321_0123);
    chk("t4_last_word", mem['h13FF], 32'h0320_0122);

    // Reset during capture at sample 100. Word 100 is written; word 101 keeps its earlier value.
    run_capture(12'h7FF, 12'h0FF, 1, -1, 100);
    chk("t5_word100", mem['h464], 32'h0163_0863);
    chk("t5_word101", mem['h465], 32'h0386_0188);
    bad_idle = 0;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (adc_we_o !== 1'b0 || csr_done_o !== 1'b0) bad_idle++;
    end
    chk("t5_idle_after_rst", bad_idle, 0);

    // A normal capture after the abandoned one.
    run_capture(12'h0F0, 12'hF0F, 1, -1, -1);
    chk("t5_first_word", mem['h400], 32'h0F0F_00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
